// File: rtl/led_cmd_pkg.sv
// -----------------------------------------------------------------------------
// led_cmd_pkg -- shared types and constants for the LED command controller.
//
// Contents:
//   HEADER_DEFAULT  default frame start byte
//   FRAME_LEN       bytes per frame including the header (6, or 7 with CHK)
//   state_t         frame-parser FSM state encoding
//
// Build option: define LED_CMD_CHKSUM_EN to add the trailing checksum byte.
// -----------------------------------------------------------------------------
package led_cmd_pkg;

   localparam logic [7:0] HEADER_DEFAULT = 8'h55;

   localparam int unsigned FRAME_LEN_BASE = 6;
   localparam int unsigned FRAME_LEN_CHK  = 7;

`ifdef LED_CMD_CHKSUM_EN
   localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
   localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

   // Each state names the byte the parser is waiting for next.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAT,
      ST_T3,
      ST_T2,
      ST_T1,
      ST_T0
`ifdef LED_CMD_CHKSUM_EN
      ,
      ST_CHK
`endif
   } state_t;

endpackage : led_cmd_pkg

// File: rtl/led_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// led_cmd_ctrl_if -- received-byte stream from the UART receiver.
//
// Signals:
//   rx_data   [7:0]  received byte
//   rx_valid         one-cycle strobe qualifying rx_data
//
// Modports:
//   master  UART receiver side (drives the stream)
//   slave   command controller side (consumes the stream)
// -----------------------------------------------------------------------------
interface led_cmd_ctrl_if;

   logic [7:0] rx_data;
   logic       rx_valid;

   modport master (output rx_data, output rx_valid);
   modport slave  (input  rx_data, input  rx_valid);

endinterface : led_cmd_ctrl_if

// File: rtl/led_cmd_timeout.sv
// -----------------------------------------------------------------------------
// led_cmd_timeout -- inter-byte timeout counter.
//
// Ports:
//   sys_clk    clock, rising edge
//   rst_n      synchronous active-low reset
//   clear_i    restart the count (a byte arrived)
//   enable_i   count while a frame is in progress; low holds the count at 0
//   expire_o   one-cycle pulse in the TIMEOUT_CYC-th consecutive idle cycle
//
// expire_o is suppressed when clear_i is high in the same cycle, so a byte
// arriving exactly at expiry wins over the timeout.
// -----------------------------------------------------------------------------
module led_cmd_timeout #(
   parameter logic [31:0] TIMEOUT_CYC = 32'd500_000
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // cnt_q holds the number of idle cycles already completed, so the cycle
   // in which it equals TIMEOUT_CYC-1 is the TIMEOUT_CYC-th idle cycle.
   assign expire_o = enable_i && !clear_i && (cnt_q == TIMEOUT_CYC - 32'd1);

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (clear_i || !enable_i || expire_o) begin
         cnt_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : led_cmd_timeout

// File: rtl/led_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// led_cmd_ctrl -- parses LED configuration frames from a UART byte stream.
//
// Frame: HEADER, PAT, T3, T2, T1, T0 [, CHK]   (time word MSB first)
//
// Ports:
//   sys_clk     clock, rising edge
//   rst_n       synchronous active-low reset
//   rx          led_cmd_ctrl_if.slave: rx_data / rx_valid byte stream
//   ctrl        registered LED pattern
//   time_ctrl   registered per-bit LED period in cycles
//   cfg_update  one-cycle pulse when ctrl/time_ctrl are loaded
//   frame_err   one-cycle pulse on a rejected or timed-out frame
//   busy        high while a frame is partially received
//
// Build option: LED_CMD_CHKSUM_EN adds a trailing CHK byte holding the
// modulo-256 sum of PAT..T0; a mismatch rejects the frame.
// -----------------------------------------------------------------------------
module led_cmd_ctrl
   import led_cmd_pkg::*;
#(
   parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
   parameter logic [7:0]  CTRL_RST    = 8'h00,
   parameter logic [31:0] TIME_RST    = 32'd50_000_000,
   parameter logic [31:0] TIMEOUT_CYC = 32'd500_000
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   led_cmd_ctrl_if.slave        rx,
   output logic [7:0]           ctrl,
   output logic [31:0]          time_ctrl,
   output logic                 cfg_update,
   output logic                 frame_err,
   output logic                 busy
);

   state_t      state_q;
   logic [7:0]  pat_q;        // shadow pattern
   logic [31:0] time_sh_q;    // shadow time word
   logic [7:0]  ctrl_q;
   logic [31:0] time_ctrl_q;
   logic        cfg_update_q;
   logic        frame_err_q;
   logic        timeout_expire;

   assign busy = (state_q != ST_IDLE);

   led_cmd_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .clear_i  (rx.rx_valid),
      .enable_i (busy),
      .expire_o (timeout_expire)
   );

`ifdef LED_CMD_CHKSUM_EN
   logic [7:0] chk_sum;
   assign chk_sum = pat_q + time_sh_q[31:24] + time_sh_q[23:16]
                  + time_sh_q[15:8] + time_sh_q[7:0];
`else
   // T0 is the final byte: its value is not in the shadow yet, so the
   // zero-time check looks at the word as it will be loaded.
   logic [31:0] time_final;
   assign time_final = {time_sh_q[31:8], rx.rx_data};
`endif

   // NOTE: reset here is synchronous (sampled on the clock edge), matching
   // the rest of this clock domain; the shadows are plain registers, not a
   // memory, so clearing them in reset is cheap.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pat_q        <= '0;
         time_sh_q    <= '0;
         ctrl_q       <= CTRL_RST;
         time_ctrl_q  <= TIME_RST;
         cfg_update_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         cfg_update_q <= 1'b0;
         frame_err_q  <= 1'b0;

         if (rx.rx_valid) begin
            case (state_q)
               ST_IDLE: begin
                  // Non-header bytes outside a frame are silently dropped.
                  if (rx.rx_data == HEADER) begin
                     state_q <= ST_PAT;
                  end
               end
               // A HEADER value inside a frame is just data: no resync.
               ST_PAT: begin
                  pat_q   <= rx.rx_data;
                  state_q <= ST_T3;
               end
               ST_T3: begin
                  time_sh_q[31:24] <= rx.rx_data;
                  state_q          <= ST_T2;
               end
               ST_T2: begin
                  time_sh_q[23:16] <= rx.rx_data;
                  state_q          <= ST_T1;
               end
               ST_T1: begin
                  time_sh_q[15:8] <= rx.rx_data;
                  state_q         <= ST_T0;
               end
`ifdef LED_CMD_CHKSUM_EN
               ST_T0: begin
                  time_sh_q[7:0] <= rx.rx_data;
                  state_q        <= ST_CHK;
               end
               ST_CHK: begin
                  if ((time_sh_q == 32'd0) || (rx.rx_data != chk_sum)) begin
                     frame_err_q <= 1'b1;
                  end else begin
                     ctrl_q       <= pat_q;
                     time_ctrl_q  <= time_sh_q;
                     cfg_update_q <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
`else
               ST_T0: begin
                  time_sh_q[7:0] <= rx.rx_data;
                  if (time_final == 32'd0) begin
                     frame_err_q <= 1'b1;
                  end else begin
                     ctrl_q       <= pat_q;
                     time_ctrl_q  <= time_final;
                     cfg_update_q <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end
`endif
               default: state_q <= ST_IDLE;
            endcase
         end else if (timeout_expire) begin
            // Abandon the partial frame; ctrl/time_ctrl keep their values.
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
         end
      end
   end

   assign ctrl       = ctrl_q;
   assign time_ctrl  = time_ctrl_q;
   assign cfg_update = cfg_update_q;
   assign frame_err  = frame_err_q;

endmodule : led_cmd_ctrl

// File: tb/tb_led_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_cmd_ctrl -- self-checking bench for led_cmd_ctrl.
// Works with or without LED_CMD_CHKSUM_EN defined.
// -----------------------------------------------------------------------------
module tb_led_cmd_ctrl;
   import led_cmd_pkg::*;

   localparam logic [31:0] TO       = 32'd16;
   localparam logic [7:0]  C_RST    = 8'h00;
   localparam logic [31:0] T_RST    = 32'd50_000_000;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ctrl;
   logic [31:0] time_ctrl;
   logic        cfg_update;
   logic        frame_err;
   logic        busy;

   led_cmd_ctrl_if rx_if ();

   led_cmd_ctrl #(
      .HEADER      (8'h55),
      .CTRL_RST    (C_RST),
      .TIME_RST    (T_RST),
      .TIMEOUT_CYC (TO)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .rx         (rx_if),
      .ctrl       (ctrl),
      .time_ctrl  (time_ctrl),
      .cfg_update (cfg_update),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   // Model of the currently loaded configuration.
   logic [7:0]  cur_ctrl;
   logic [31:0] cur_time;

   typedef struct {
      logic [47:0] bytes;    // HEADER..T0, first byte in the MSBs
      logic [7:0]  chk;
      logic        accept;
      logic [7:0]  exp_ctrl;
      logic [31:0] exp_time;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive one byte; returns on the negedge after the consuming posedge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge sys_clk);
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      @(negedge sys_clk);
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input string name, input logic [47:0] bytes, input logic [7:0] chk);
      logic [7:0] b;
      for (int i = 0; i < int'(FRAME_LEN); i++) begin
         b = (i < 6) ? bytes[47-8*i -: 8] : chk;
         if (i == int'(FRAME_LEN) - 1) begin
            // Outputs must not move before the final byte.
            check({name, " held ctrl"}, 32'(ctrl), 32'(cur_ctrl));
            check({name, " held time"}, time_ctrl, cur_time);
            check({name, " busy mid"}, 32'(busy), 32'd1);
         end
         send_byte(b);
      end
   endtask

   task automatic expect_result(input string name, input logic accept,
                                input logic [7:0] ec, input logic [31:0] et);
      check({name, " cfg_update"}, 32'(cfg_update), 32'(accept));
      check({name, " frame_err"}, 32'(frame_err), 32'(!accept));
      check({name, " ctrl"}, 32'(ctrl), 32'(ec));
      check({name, " time_ctrl"}, time_ctrl, et);
      check({name, " busy"}, 32'(busy), 32'd0);
      @(negedge sys_clk);
      check({name, " pulse end"}, 32'({cfg_update, frame_err}), 32'd0);
      cur_ctrl = ec;
      cur_time = et;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic early;

      vecs[0] = '{48'h55A50000000A, 8'hAF, 1'b1, 8'hA5, 32'h0000000A};
      vecs[1] = '{48'h550F00000000, 8'h0F, 1'b0, 8'hA5, 32'h0000000A};
      vecs[2] = '{48'h553C12345678, 8'h50, 1'b1, 8'h3C, 32'h12345678};
      vecs[3] = '{48'h555555555555, 8'hA9, 1'b1, 8'h55, 32'h55555555};
      vecs[4] = '{48'h5500FFFFFFFF, 8'hFC, 1'b1, 8'h00, 32'hFFFFFFFF};
      vecs[5] = '{48'h55FF00000100, 8'h00, 1'b1, 8'hFF, 32'h00000100};

      rst_n          = 1'b0;
      rx_if.rx_data  = 8'h00;
      rx_if.rx_valid = 1'b0;
      cur_ctrl       = C_RST;
      cur_time       = T_RST;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("reset ctrl", 32'(ctrl), 32'(C_RST));
      check("reset time", time_ctrl, T_RST);
      check("reset pulses", 32'({cfg_update, frame_err, busy}), 32'd0);
      rst_n = 1'b1;

      // Garbage bytes in IDLE are ignored, then a zero-time frame is rejected
      send_byte(8'h12);
      check("garbage 12", 32'({busy, frame_err}), 32'd0);
      send_byte(8'h34);
      check("garbage 34", 32'({busy, frame_err}), 32'd0);
      send_frame("zero time", 48'h550F00000000, 8'h0F);
      expect_result("zero time", 1'b0, C_RST, T_RST);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         send_frame($sformatf("vec%0d", i), vecs[i].bytes, vecs[i].chk);
         expect_result($sformatf("vec%0d", i), vecs[i].accept, vecs[i].exp_ctrl, vecs[i].exp_time);
      end

`ifdef LED_CMD_CHKSUM_EN
      send_frame("bad chk", 48'h55FF00000100, 8'h01);
      expect_result("bad chk", 1'b0, 8'hFF, 32'h00000100);
`endif

      // Inter-byte timeout aborts a partial frame
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      early = 1'b0;
      for (int i = 0; i < int'(TO) - 1; i++) begin
         @(negedge sys_clk);
         if (frame_err || !busy) early = 1'b1;
      end
      check("timeout early", 32'(early), 32'd0);
      @(negedge sys_clk);
      check("timeout err", 32'(frame_err), 32'd1);
      check("timeout busy", 32'(busy), 32'd0);
      check("timeout outputs", time_ctrl, cur_time);
      @(negedge sys_clk);
      check("timeout pulse end", 32'(frame_err), 32'd0);
      send_frame("after timeout", 48'h5566000000C8, 8'h2E);
      expect_result("after timeout", 1'b1, 8'h66, 32'd200);

      // Byte arriving in the exact expiry cycle is consumed, no abort
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      repeat (int'(TO) - 2) @(negedge sys_clk);
      send_byte(8'h00);
      check("expiry race err", 32'(frame_err), 32'd0);
      check("expiry race busy", 32'(busy), 32'd1);
      send_byte(8'h07);
`ifdef LED_CMD_CHKSUM_EN
      send_byte(8'h08);
`endif
      expect_result("expiry race", 1'b1, 8'h01, 32'd7);

      // Reset in the middle of a frame
      send_byte(8'h55);
      send_byte(8'h22);
      send_byte(8'h33);
      rst_n = 1'b0;
      @(negedge sys_clk);
      check("midrst pulses", 32'({cfg_update, frame_err, busy}), 32'd0);
      check("midrst ctrl", 32'(ctrl), 32'(C_RST));
      check("midrst time", time_ctrl, T_RST);
      rst_n = 1'b1;
      cur_ctrl = C_RST;
      cur_time = T_RST;
      @(negedge sys_clk);
      check("midrst after", 32'({cfg_update, frame_err, busy}), 32'd0);
      send_frame("post reset", 48'h55A50000000A, 8'hAF);
      expect_result("post reset", 1'b1, 8'hA5, 32'h0000000A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_led_cmd_ctrl

// File: doc/led_cmd_ctrl.md
LED_CMD_CTRL -- requirements
Module: led_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'h55, meaning the frame start byte.
REQ-002 The block SHALL have parameter CTRL_RST, default 8'h00, meaning the ctrl value after reset.
REQ-003 The block SHALL have parameter TIME_RST, default 32'd50_000_000, meaning the time_ctrl value after reset.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 32'd500_000, meaning the inter-byte timeout in sys_clk cycles.
REQ-005 Port sys_clk  input  1  clock; all logic rising-edge.
REQ-006 Port rst_n  input  1  reset; synchronous, active-low.
REQ-007 Port rx_data  input  8  received UART byte.
REQ-008 Port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-009 Port ctrl  output  8  registered LED pattern driven to the LED sequencer.
REQ-010 Port time_ctrl  output  32  registered per-bit LED period in cycles.
REQ-011 Port cfg_update  output  1  one-cycle pulse when ctrl/time_ctrl are loaded.
REQ-012 Port frame_err  output  1  one-cycle pulse on a rejected or aborted frame.
REQ-013 Port busy  output  1  high while a frame is partially received (state not IDLE).

Function
REQ-014 Frame format SHALL be HEADER, PAT, T3, T2, T1, T0[, CHK], with time MSB first (T3 = bits 31:24).
REQ-015 FSM states SHALL be IDLE, PAT, T3, T2, T1, T0, CHK; each rx_valid advances exactly one state.
REQ-016 In IDLE, rx_valid with rx_data==HEADER SHALL go to PAT; any other byte SHALL be ignored with no frame_err.
REQ-017 PAT and T3..T0 bytes SHALL be held in shadow registers; ctrl/time_ctrl SHALL NOT change before frame completion.
REQ-018 On the final byte, if accepted, ctrl and time_ctrl SHALL load from the shadows on the next edge, with cfg_update high that same cycle, and the FSM returns to IDLE.
REQ-019 Shadow time value 0 SHALL be rejected: frame_err pulses, outputs hold, FSM returns to IDLE.
REQ-020 A HEADER byte received mid-frame SHALL be treated as data, not as a resync.
REQ-021 Outside IDLE, TIMEOUT_CYC cycles without rx_valid SHALL abort the frame: frame_err pulses, the FSM goes to IDLE, and outputs hold.
REQ-022 The timeout counter SHALL clear on every rx_valid and while in IDLE; rx_valid in the same cycle as expiry SHALL take priority and be consumed normally.
REQ-023 cfg_update and frame_err SHALL never be high in the same cycle; both SHALL be registered.
REQ-024 Latency from the final rx_valid to the updated ctrl/time_ctrl SHALL be exactly 1 cycle.

Reset
REQ-025 While rst_n=0: FSM=IDLE, ctrl=CTRL_RST, time_ctrl=TIME_RST, shadows=0, timeout counter=0, cfg_update=0, frame_err=0, busy=0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no pulse on any output.

Configuration
REQ-027 With LED_CMD_CHKSUM_EN defined, the frame SHALL include CHK (8-bit modulo-256 sum of PAT, T3, T2, T1, T0); on mismatch, frame_err pulses and outputs hold.
REQ-028 Without LED_CMD_CHKSUM_EN, the CHK state and the checksum adder SHALL not exist, and T0 SHALL be the final byte.

Structure
REQ-029 Package led_cmd_pkg SHALL hold the state enum typedef, the default HEADER constant, and the frame-length constants (6 or 7 bytes).
REQ-030 Sub-module led_cmd_timeout (clear, enable, expire pulse) SHALL implement the inter-byte timeout counter.

Verification
REQ-031 Bytes 55 A5 00 00 00 0A (+CHK AF) -> ctrl=8'hA5, time_ctrl=10, cfg_update for exactly 1 cycle, 1 cycle after the last byte.
REQ-032 Bytes 12 34 then 55 0F 00 00 00 00 (+0F) -> 12/34 ignored, frame_err pulses, ctrl/time_ctrl remain at reset values.
REQ-033 Bytes 55 01 00 00, then idle TIMEOUT_CYC cycles -> frame_err at expiry, busy falls, a following valid frame is accepted.
REQ-034 (CHKSUM_EN) 55 FF 00 00 01 00 CHK=00 (correct is 00) -> accepted; same frame with CHK=01 -> frame_err, outputs unchanged.
REQ-035 rst_n asserted after 3 bytes of a frame -> no pulses, busy=0, outputs at reset values; the next full frame loads correctly.
REQ-036 rx_valid asserted in the exact timeout-expiry cycle -> byte consumed, no frame_err.
